execute_forward_datapath: RTL and testbench
===========================================

# execute_forward_datapath

Execute/data-memory datapath that consumes the decode-side control stream (op_dec, mux_sel_A/B, imm_sel, imm, mem_en_ex, mem_rw_ex, mem_mux_sel_dm). It resolves forwarded operands, runs the ALU, and drives the data-memory port. It holds the EX, DM and WB result registers that the forwarding selects point at, and produces write-back data for the register file. It sits between the register file/dependency-check stage and data memory.

## Interface
- DATA_W, 8, datapath width (imm is 8 bits, zero-extended if DATA_W > 8)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; clears every register
- op_dec  input  5  opcode of the instruction in decode stage
- mux_sel_A  input  2  operand A source: 00 rf_A, 01 ans_ex, 10 dm_out, 11 ans_wb
- mux_sel_B  input  2  operand B source, same encoding
- imm_sel  input  1  1: ALU operand B is imm instead of forwarded B
- imm  input  8  immediate for the decode-stage instruction
- rf_A, rf_B  input  DATA_W  register-file read data for the decode-stage operands
- mem_en_ex  input  1  memory access for the instruction now in EX
- mem_rw_ex  input  1  1 store, 0 load (EX-aligned)
- mem_mux_sel_dm  input  1  1: DM-stage result is dm_rdata (load)
- dm_rdata  input  DATA_W  synchronous memory read data, valid the cycle after the request
- dm_en  output  1  = mem_en_ex
- dm_rw  output  1  = mem_rw_ex
- dm_addr  output  DATA_W  = ans_ex
- dm_wdata  output  DATA_W  = st_ex
- wb_data  output  DATA_W  = dm_out; register file writes it at the next edge using RW_dm
- flag_c, flag_z  output  1  registered carry and zero flags

## Operation
- Operand A = mux(mux_sel_A); fwd B = mux(mux_sel_B); ALU B = imm_sel ? imm : fwd B.
- ALU ops, for op_dec[4:3] = 00 (register) or 01 (immediate), function op_dec[2:0]:
  - 000 ADD (A+B)
  - 001 SUB (A−B)
  - 010 MOV (B)
  - 011 AND
  - 100 OR
  - 101 XOR
  - 110 NOT A
  - 111 NAND
- ADD and SUB are DATA_W+1 wide:
  - ADD: carry = bit DATA_W.
  - SUB: carry = borrow, 1 when A < B unsigned.
  - Result is truncated to DATA_W; wraps modulo 2^DATA_W.
- Flag updates:
  - flag_z <= (result == 0) on every 00xxx/01xxx op.
  - flag_c updates only on ADD/SUB.
  - All other opcodes leave both flags unchanged.
- LD 10100 and ST 10101: ALU result = operand A (the address). st_ex <= fwd B. For ST, fwd B is still used even if imm_sel = 1.
- All other 1xxxx opcodes (JMP, conditional jumps, unused) give ALU result = 0 and no flag change.
- Pipeline registers, updated every edge, no enable:
  - ans_ex <= ALU result
  - st_ex <= fwd B
  - ans_dm <= ans_ex
  - ans_wb <= dm_out
- dm_out = mem_mux_sel_dm ? dm_rdata : ans_dm (combinational).
- Forward 10 selects dm_out, so load data forwards to a dependent instruction two cycles behind the load.
- Simultaneous conditions:
  - If mux_sel_A == mux_sel_B, both operands take the same source.
  - No hazard detection is done here; select priority is decided upstream.

## Timing
- Reset (asynchronous assert, synchronous release at the next edge): ans_ex, st_ex, ans_dm, ans_wb, flag_c, flag_z = 0. Consequently:
  - dm_addr = 0, dm_wdata = 0.
  - wb_data = 0 unless mem_mux_sel_dm = 1.
  - dm_en and dm_rw follow their inputs combinationally.
- Reset asserted mid-stream clears all in-flight results in the same cycle. The first instruction after release sees 0 on every forwarded source.
- Decode cycle N: operands and ALU are combinational from inputs in cycle N. The result lands in ans_ex at edge N+1.
- EX cycle N+1: dm_addr and dm_wdata are valid, aligned with mem_en_ex/mem_rw_ex.
- DM cycle N+2: dm_rdata or ans_dm appears on wb_data/dm_out. Register-file write happens at edge N+3.
- WB cycle N+3: ans_wb holds the written value, covering the write-then-read in the same cycle.
- Flags are visible one cycle after the ALU op, together with ans_ex.
- Latency: decode to wb_data is 2 cycles.

## Test plan
- Reset: drive reset=0 mid-run with ans_ex=0x5A → all outputs and flags read 0 in the same cycle; they stay 0 for one cycle after release with NOP (op 11000).
- Forward chain:
  - ADD rf_A=0x10, rf_B=0x05, then ADD with sel_A=01, rf_B=0x01.
  - → ans_ex 0x15, then 0x16; wb_data 0x15 at cycle N+2.
- Carry and wrap:
  - ADD 0xFF+0x01 → ans_ex 0x00, flag_c=1, flag_z=1.
  - Next SUB 0x03−0x05 → ans_ex 0xFE, flag_c=1, flag_z=0.
  - Next JMP → flags unchanged.
- Immediate: op 01000, imm_sel=1, imm=0x22, rf_A=0x11, rf_B=0x99 → ans_ex 0x33.
- Store: ST with sel_A=00 rf_A=0x40, sel_B=01 (ans_ex=0x7C), mem_en_ex=1, mem_rw_ex=1 next cycle → dm_addr 0x40, dm_wdata 0x7C, dm_en=1, dm_rw=1.
- Load-use:
  - LD address 0x40, dm_rdata=0xC3, mem_mux_sel_dm=1 at DM.
  - Dependent ADD with sel_A=10, imm_sel=1, imm=0x01 → ans_ex 0xC4.
  - Following op with sel_A=11 reads ans_wb=0xC3.

Source files
------------

// File: rtl/execute_forward_if.sv
// Decode-side control/operand stream into the execute datapath, plus the
// data-memory port, write-back data and flags coming back out.
interface execute_forward_if #(
  parameter int unsigned DATA_W = 8
);
  logic [4:0]        op_dec;
  logic [1:0]        mux_sel_A;
  logic [1:0]        mux_sel_B;
  logic              imm_sel;
  logic [7:0]        imm;
  logic [DATA_W-1:0] rf_A;
  logic [DATA_W-1:0] rf_B;
  logic              mem_en_ex;
  logic              mem_rw_ex;
  logic              mem_mux_sel_dm;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_en;
  logic              dm_rw;
  logic [DATA_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] wb_data;
  logic              flag_c;
  logic              flag_z;

  modport master (
    output op_dec, mux_sel_A, mux_sel_B, imm_sel, imm, rf_A, rf_B,
           mem_en_ex, mem_rw_ex, mem_mux_sel_dm, dm_rdata,
    input  dm_en, dm_rw, dm_addr, dm_wdata, wb_data, flag_c, flag_z
  );

  modport slave (
    input  op_dec, mux_sel_A, mux_sel_B, imm_sel, imm, rf_A, rf_B,
           mem_en_ex, mem_rw_ex, mem_mux_sel_dm, dm_rdata,
    output dm_en, dm_rw, dm_addr, dm_wdata, wb_data, flag_c, flag_z
  );
endinterface

// File: rtl/execute_forward_datapath.sv
// Execute/data-memory datapath: operand forwarding, ALU, EX/DM/WB result
// registers, data-memory port drive and write-back data.
module execute_forward_datapath #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  execute_forward_if.slave  bus_if
);

  localparam int unsigned SUM_W = DATA_W + 1;

  localparam logic [2:0] FN_ADD  = 3'b000;
  localparam logic [2:0] FN_SUB  = 3'b001;
  localparam logic [2:0] FN_MOV  = 3'b010;
  localparam logic [2:0] FN_AND  = 3'b011;
  localparam logic [2:0] FN_OR   = 3'b100;
  localparam logic [2:0] FN_XOR  = 3'b101;
  localparam logic [2:0] FN_NOT  = 3'b110;
  localparam logic [2:0] FN_NAND = 3'b111;

  localparam logic [4:0] OP_LD = 5'b10100;
  localparam logic [4:0] OP_ST = 5'b10101;

  typedef logic [DATA_W-1:0] word_t;

  word_t            ans_ex_q, ans_ex_d;
  word_t            st_ex_q;
  word_t            ans_dm_q;
  word_t            ans_wb_q;
  logic             flag_c_q, flag_c_d;
  logic             flag_z_q, flag_z_d;

  word_t            dm_out_c;
  word_t            opa_c;
  word_t            fwd_b_c;
  word_t            alu_b_c;
  logic [SUM_W-1:0] add_c;
  logic [SUM_W-1:0] sub_c;

  // Forwarding source select shared by both operands.
  function automatic word_t fwd_pick(input logic [1:0] sel, input word_t rf,
                                     input word_t ex, input word_t dm,
                                     input word_t wb);
    case (sel)
      2'b00:   fwd_pick = rf;
      2'b01:   fwd_pick = ex;
      2'b10:   fwd_pick = dm;
      default: fwd_pick = wb;
    endcase
  endfunction

  // DM-stage result, operand muxes and the wide add/subtract paths.
  always_comb begin
    dm_out_c = bus_if.mem_mux_sel_dm ? bus_if.dm_rdata : ans_dm_q;
    opa_c    = fwd_pick(bus_if.mux_sel_A, bus_if.rf_A, ans_ex_q, dm_out_c, ans_wb_q);
    fwd_b_c  = fwd_pick(bus_if.mux_sel_B, bus_if.rf_B, ans_ex_q, dm_out_c, ans_wb_q);
    alu_b_c  = bus_if.imm_sel ? DATA_W'(bus_if.imm) : fwd_b_c;
    add_c    = SUM_W'(opa_c) + SUM_W'(alu_b_c);
    sub_c    = SUM_W'(opa_c) - SUM_W'(alu_b_c);
  end

  // ALU result and flag next-state; memory ops pass the address through.
  always_comb begin
    ans_ex_d = '0;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    if (!bus_if.op_dec[4]) begin
      case (bus_if.op_dec[2:0])
        FN_ADD: begin
          ans_ex_d = add_c[DATA_W-1:0];
          flag_c_d = add_c[DATA_W];
        end
        FN_SUB: begin
          ans_ex_d = sub_c[DATA_W-1:0];
          flag_c_d = sub_c[DATA_W];
        end
        FN_MOV:  ans_ex_d = alu_b_c;
        FN_AND:  ans_ex_d = opa_c & alu_b_c;
        FN_OR:   ans_ex_d = opa_c | alu_b_c;
        FN_XOR:  ans_ex_d = opa_c ^ alu_b_c;
        FN_NOT:  ans_ex_d = ~opa_c;
        FN_NAND: ans_ex_d = ~(opa_c & alu_b_c);
        default: ans_ex_d = '0;
      endcase
      flag_z_d = (ans_ex_d == '0);
    end else if (bus_if.op_dec == OP_LD || bus_if.op_dec == OP_ST) begin
      ans_ex_d = opa_c;
    end
  end

  // Pipeline result registers and flags; free-running, cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ans_ex_q <= '0;
      st_ex_q  <= '0;
      ans_dm_q <= '0;
      ans_wb_q <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      ans_ex_q <= ans_ex_d;
      st_ex_q  <= fwd_b_c;
      ans_dm_q <= ans_ex_q;
      ans_wb_q <= dm_out_c;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign bus_if.dm_en    = bus_if.mem_en_ex;
  assign bus_if.dm_rw    = bus_if.mem_rw_ex;
  assign bus_if.dm_addr  = ans_ex_q;
  assign bus_if.dm_wdata = st_ex_q;
  assign bus_if.wb_data  = dm_out_c;
  assign bus_if.flag_c   = flag_c_q;
  assign bus_if.flag_z   = flag_z_q;

endmodule

// File: tb/tb_execute_forward_datapath.sv
// Directed bench for execute_forward_datapath: forwarding, ALU/flags,
// store/load ports, load-use forwarding and mid-stream reset.
module tb_execute_forward_datapath;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_bad;

  execute_forward_if #(.DATA_W(8)) bus ();

  execute_forward_datapath #(.DATA_W(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [1:0] sa, input logic [1:0] sb,
                       input logic isel, input logic [7:0] im,
                       input logic [7:0] ra, input logic [7:0] rb);
    bus.op_dec    = op;
    bus.mux_sel_A = sa;
    bus.mux_sel_B = sb;
    bus.imm_sel   = isel;
    bus.imm       = im;
    bus.rf_A      = ra;
    bus.rf_B      = rb;
  endtask

  task automatic mem(input logic en, input logic rw, input logic msel, input logic [7:0] rd);
    bus.mem_en_ex      = en;
    bus.mem_rw_ex      = rw;
    bus.mem_mux_sel_dm = msel;
    bus.dm_rdata       = rd;
  endtask

  localparam logic [4:0] ADD  = 5'b00000;
  localparam logic [4:0] SUB  = 5'b00001;
  localparam logic [4:0] MOV  = 5'b00010;
  localparam logic [4:0] AND_ = 5'b00011;
  localparam logic [4:0] NOT_ = 5'b00110;
  localparam logic [4:0] NAND = 5'b00111;
  localparam logic [4:0] ADDI = 5'b01000;
  localparam logic [4:0] JMP  = 5'b10000;
  localparam logic [4:0] LD   = 5'b10100;
  localparam logic [4:0] ST   = 5'b10101;
  localparam logic [4:0] NOP  = 5'b11000;

  initial begin
    n_chk = 0;
    n_bad = 0;
    reset = 1'b0;
    issue(NOP, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00);
    mem(1'b1, 1'b1, 1'b0, 8'h00);
    tick();
    tick();
    // Reset state; memory strobes follow their inputs.
    chk("rst_addr",  32'(bus.dm_addr),  32'h00);
    chk("rst_wdata", 32'(bus.dm_wdata), 32'h00);
    chk("rst_wb",    32'(bus.wb_data),  32'h00);
    chk("rst_flags", 32'({bus.flag_c, bus.flag_z}), 32'h0);
    chk("rst_dm_en", 32'(bus.dm_en), 32'h1);
    chk("rst_dm_rw", 32'(bus.dm_rw), 32'h1);
    mem(1'b0, 1'b0, 1'b0, 8'h00);
    reset = 1'b1;

    // Forward chain: EX result feeds operand A of the next op.
    issue(ADD, 2'b00, 2'b00, 1'b0, 8'h00, 8'h10, 8'h05);
    tick();
    chk("fwd1_ex", 32'(bus.dm_addr), 32'h15);
    issue(ADD, 2'b01, 2'b00, 1'b0, 8'h00, 8'h00, 8'h01);
    tick();
    chk("fwd2_ex", 32'(bus.dm_addr), 32'h16);
    chk("fwd1_wb", 32'(bus.wb_data), 32'h15);

    // Carry, wrap, borrow; JMP leaves flags alone.
    issue(ADD, 2'b00, 2'b00, 1'b0, 8'h00, 8'hFF, 8'h01);
    tick();
    chk("wrap_ex", 32'(bus.dm_addr), 32'h00);
    chk("wrap_cz", 32'({bus.flag_c, bus.flag_z}), 32'h3);
    issue(SUB, 2'b00, 2'b00, 1'b0, 8'h00, 8'h03, 8'h05);
    tick();
    chk("sub_ex", 32'(bus.dm_addr), 32'hFE);
    chk("sub_cz", 32'({bus.flag_c, bus.flag_z}), 32'h2);
    issue(JMP, 2'b00, 2'b00, 1'b0, 8'h00, 8'h03, 8'h05);
    tick();
    chk("jmp_ex", 32'(bus.dm_addr), 32'h00);
    chk("jmp_cz", 32'({bus.flag_c, bus.flag_z}), 32'h2);

    // Logic ops: Z tracks result, C held from SUB.
    issue(AND_, 2'b00, 2'b00, 1'b0, 8'h00, 8'hF0, 8'h3C);
    tick();
    chk("and_ex", 32'(bus.dm_addr), 32'h30);
    issue(NAND, 2'b00, 2'b00, 1'b0, 8'h00, 8'hF0, 8'h3C);
    tick();
    chk("nand_ex", 32'(bus.dm_addr), 32'hCF);
    issue(NOT_, 2'b00, 2'b00, 1'b0, 8'h00, 8'h0F, 8'hAA);
    tick();
    chk("not_ex", 32'(bus.dm_addr), 32'hF0);
    issue(MOV, 2'b00, 2'b00, 1'b0, 8'h00, 8'h77, 8'h00);
    tick();
    chk("mov_ex", 32'(bus.dm_addr), 32'h00);
    chk("mov_cz", 32'({bus.flag_c, bus.flag_z}), 32'h3);

    // Immediate replaces forwarded B for the ALU, store path still sees B.
    issue(ADDI, 2'b00, 2'b00, 1'b1, 8'h22, 8'h11, 8'h99);
    tick();
    chk("imm_ex", 32'(bus.dm_addr), 32'h33);
    chk("imm_st", 32'(bus.dm_wdata), 32'h99);
    chk("imm_cz", 32'({bus.flag_c, bus.flag_z}), 32'h0);

    // Store: address from rf_A, data forwarded from EX (imm_sel ignored).
    issue(MOV, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00, 8'h7C);
    tick();
    chk("pre_st_ex", 32'(bus.dm_addr), 32'h7C);
    issue(ST, 2'b00, 2'b01, 1'b1, 8'h55, 8'h40, 8'h00);
    tick();
    mem(1'b1, 1'b1, 1'b0, 8'h00);
    issue(LD, 2'b00, 2'b00, 1'b0, 8'h00, 8'h40, 8'h00);
    #1;
    chk("st_addr",  32'(bus.dm_addr),  32'h40);
    chk("st_wdata", 32'(bus.dm_wdata), 32'h7C);
    chk("st_en_rw", 32'({bus.dm_en, bus.dm_rw}), 32'h3);

    // Load-use: DM read data forwards to the op two cycles behind the load.
    tick();
    mem(1'b1, 1'b0, 1'b0, 8'h00);
    issue(NOP, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00);
    #1;
    chk("ld_addr",  32'(bus.dm_addr), 32'h40);
    chk("ld_en_rw", 32'({bus.dm_en, bus.dm_rw}), 32'h2);
    tick();
    mem(1'b0, 1'b0, 1'b1, 8'hC3);
    issue(ADDI, 2'b10, 2'b00, 1'b1, 8'h01, 8'h00, 8'h00);
    #1;
    chk("ld_wb", 32'(bus.wb_data), 32'hC3);
    tick();
    mem(1'b0, 1'b0, 1'b0, 8'h00);
    issue(ADD, 2'b11, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00);
    #1;
    chk("lu_ex", 32'(bus.dm_addr), 32'hC4);
    tick();
    chk("wbfwd_ex", 32'(bus.dm_addr), 32'hC3);
    chk("lu_wb",    32'(bus.wb_data), 32'hC4);

    // Mid-stream reset with 0x5A in EX and carry set.
    issue(ADD, 2'b00, 2'b00, 1'b0, 8'h00, 8'hFF, 8'h5B);
    tick();
    chk("pre_rst_ex", 32'(bus.dm_addr), 32'h5A);
    chk("pre_rst_cz", 32'({bus.flag_c, bus.flag_z}), 32'h2);
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_addr",  32'(bus.dm_addr),  32'h00);
    chk("mid_rst_wdata", 32'(bus.dm_wdata), 32'h00);
    chk("mid_rst_wb",    32'(bus.wb_data),  32'h00);
    chk("mid_rst_cz",    32'({bus.flag_c, bus.flag_z}), 32'h0);
    tick();
    reset = 1'b1;
    issue(NOP, 2'b00, 2'b00, 1'b0, 8'h00, 8'h12, 8'h34);
    tick();
    chk("post_rst_addr", 32'(bus.dm_addr), 32'h00);
    chk("post_rst_wb",   32'(bus.wb_data), 32'h00);
    chk("post_rst_cz",   32'({bus.flag_c, bus.flag_z}), 32'h0);
    issue(ADD, 2'b11, 2'b01, 1'b0, 8'h00, 8'h12, 8'h34);
    tick();
    chk("post_rst_fwd", 32'(bus.dm_addr), 32'h00);
    chk("post_rst_z",   32'({bus.flag_c, bus.flag_z}), 32'h1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
